l2_port_arbiter: RTL and testbench

- Shares the single next-level (L2) request port between the instruction cache miss path and the data cache miss/writeback path.
- Arbitrates round-robin, holds exactly one outstanding L2 transaction, and waits for the L2 acknowledge.
- Aborts on timeout and keeps per-requester saturating grant counters for the statistics module.

---
 rtl/l2_port_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L2 request port between the instruction
// cache fill path and the data cache fill/writeback path. It arbitrates
// round-robin and keeps one L2 transaction in flight. A stuck transaction is
// aborted after TIMEOUT cycles. Saturating per-requester counters record
// every completed grant.
module l2_port_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_done,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  output logic              dc_gnt,
  output logic              dc_done,
  output logic              l2_req,
  output logic              l2_we,
  output logic [ADDR_W-1:0] l2_addr,
  input  logic              l2_ack,
  output logic              err,
  output logic              busy,
  output logic [CNT_W-1:0]  ic_cnt,
  output logic [CNT_W-1:0]  dc_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Owner encoding: the instruction cache is 0 and the data cache is 1.
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  // The wait counter is 8 bits wide because TIMEOUT can be at most 255.
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  // Width-matched increment constant for the grant counters.
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_owner_q, last_owner_d;
  logic [7:0]         tcnt_q, tcnt_d;
  logic               l2_req_q, l2_req_d;
  logic               l2_we_q, l2_we_d;
  logic [ADDR_W-1:0]  l2_addr_q, l2_addr_d;
  logic               ic_gnt_q, ic_gnt_d;
  logic               dc_gnt_q, dc_gnt_d;
  logic               ic_done_q, ic_done_d;
  logic               dc_done_q, dc_done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   ic_cnt_q, ic_cnt_d;
  logic [CNT_W-1:0]   dc_cnt_q, dc_cnt_d;
  logic               pick_dc;

  // Decide which requester wins a grant in IDLE.
  // A lone request always wins. On a tie, the requester that did not own
  // the previous transaction wins, so continuous requests alternate.
  always_comb begin
    pick_dc = 1'b0;
    if (dc_req && (!ic_req || (last_owner_q == OWN_IC))) begin
      pick_dc = 1'b1;
    end
  end

  // Compute the next state and the next value of every registered output.
  // Pulses default to zero, and everything else holds its value unless the
  // FSM updates it.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    tcnt_d       = tcnt_q;
    l2_req_d     = l2_req_q;
    l2_we_d      = l2_we_q;
    l2_addr_d    = l2_addr_q;
    ic_cnt_d     = ic_cnt_q;
    dc_cnt_d     = dc_cnt_q;
    ic_gnt_d     = 1'b0;
    dc_gnt_d     = 1'b0;
    ic_done_d    = 1'b0;
    dc_done_d    = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ic_req || dc_req) begin
          tcnt_d   = 8'd0;
          l2_req_d = 1'b1;
          state_d  = S_WAIT;
          if (pick_dc) begin
            owner_d   = OWN_DC;
            l2_addr_d = dc_addr;
            l2_we_d   = dc_we;
            dc_gnt_d  = 1'b1;
          end else begin
            owner_d   = OWN_IC;
            l2_addr_d = ic_addr;
            l2_we_d   = 1'b0;
            ic_gnt_d  = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (l2_ack) begin
          // A completed transaction updates the owner's counter. The
          // counter saturates at all-ones.
          l2_req_d     = 1'b0;
          last_owner_d = owner_q;
          state_d      = S_DONE;
          if (owner_q == OWN_DC) begin
            dc_done_d = 1'b1;
            if (dc_cnt_q != '1) begin
              dc_cnt_d = dc_cnt_q + CNT_ONE;
            end
          end else begin
            ic_done_d = 1'b1;
            if (ic_cnt_q != '1) begin
              ic_cnt_d = ic_cnt_q + CNT_ONE;
            end
          end
        end else if (tcnt_q == TLAST) begin
          // A timeout aborts the transaction. The owner still gets its done
          // pulse so that it stops waiting, but the abort is not counted.
          l2_req_d     = 1'b0;
          last_owner_d = owner_q;
          err_d        = 1'b1;
          state_d      = S_DONE;
          if (owner_q == OWN_DC) begin
            dc_done_d = 1'b1;
          end else begin
            ic_done_d = 1'b1;
          end
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        l2_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers. Reset clears everything and makes the data
  // cache the last owner, so the instruction cache wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IC;
      last_owner_q <= OWN_DC;
      tcnt_q       <= 8'd0;
      l2_req_q     <= 1'b0;
      l2_we_q      <= 1'b0;
      l2_addr_q    <= '0;
      ic_gnt_q     <= 1'b0;
      dc_gnt_q     <= 1'b0;
      ic_done_q    <= 1'b0;
      dc_done_q    <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      ic_cnt_q     <= '0;
      dc_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      tcnt_q       <= tcnt_d;
      l2_req_q     <= l2_req_d;
      l2_we_q      <= l2_we_d;
      l2_addr_q    <= l2_addr_d;
      ic_gnt_q     <= ic_gnt_d;
      dc_gnt_q     <= dc_gnt_d;
      ic_done_q    <= ic_done_d;
      dc_done_q    <= dc_done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      ic_cnt_q     <= ic_cnt_d;
      dc_cnt_q     <= dc_cnt_d;
    end
  end

  assign ic_gnt  = ic_gnt_q;
  assign dc_gnt  = dc_gnt_q;
  assign ic_done = ic_done_q;
  assign dc_done = dc_done_q;
  assign l2_req  = l2_req_q;
  assign l2_we   = l2_we_q;
  assign l2_addr = l2_addr_q;
  assign err     = err_q;
  assign busy    = busy_q;
  assign ic_cnt  = ic_cnt_q;
  assign dc_cnt  = dc_cnt_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Testbench for l2_port_arbiter. It uses directed scenarios with
// hand-computed expectations. The DUT is built with a short timeout and
// narrow counters, so the abort path and counter saturation are reachable
// in a few cycles.
module tb_l2_port_arbiter;

  localparam int ADDR_W  = 26;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ic_req = 1'b0;
  logic [ADDR_W-1:0] ic_addr = '0;
  logic              ic_gnt;
  logic              ic_done;
  logic              dc_req = 1'b0;
  logic              dc_we = 1'b0;
  logic [ADDR_W-1:0] dc_addr = '0;
  logic              dc_gnt;
  logic              dc_done;
  logic              l2_req;
  logic              l2_we;
  logic [ADDR_W-1:0] l2_addr;
  logic              l2_ack = 1'b0;
  logic              err;
  logic              busy;
  logic [CNT_W-1:0]  ic_cnt;
  logic [CNT_W-1:0]  dc_cnt;

  int checks = 0;
  int errors = 0;

  l2_port_arbiter #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ic_req (ic_req),
    .ic_addr(ic_addr),
    .ic_gnt (ic_gnt),
    .ic_done(ic_done),
    .dc_req (dc_req),
    .dc_we  (dc_we),
    .dc_addr(dc_addr),
    .dc_gnt (dc_gnt),
    .dc_done(dc_done),
    .l2_req (l2_req),
    .l2_we  (l2_we),
    .l2_addr(l2_addr),
    .l2_ack (l2_ack),
    .err    (err),
    .busy   (busy),
    .ic_cnt (ic_cnt),
    .dc_cnt (dc_cnt)
  );

  // Free-running clock with a 10-time-unit period.
  always #5 clk = ~clk;

  // Advance one rising edge. Inputs are driven, and outputs are sampled,
  // 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({ic_gnt, dc_gnt, ic_done, dc_done, l2_req, l2_we, err, busy} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 00000000",
               {ic_gnt, dc_gnt, ic_done, dc_done, l2_req, l2_we, err, busy});
    end
    checks++;
    if ({l2_addr, ic_cnt, dc_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: addr %h ic_cnt %0d dc_cnt %0d expected all 0",
               l2_addr, ic_cnt, dc_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_ic();
    ic_addr = 26'h0ABCDE;
    ic_req  = 1'b1;
    tick();
    checks++;
    if ({ic_gnt, dc_gnt, l2_req, l2_we, busy} !== 5'b10101 || l2_addr !== 26'h0ABCDE) begin
      errors++;
      $display("[TB] FAIL single_grant: gnt %b%b req %b we %b busy %b addr %h expected 1 0 1 0 1 0abcde",
               ic_gnt, dc_gnt, l2_req, l2_we, busy, l2_addr);
    end
    ic_req  = 1'b0;
    ic_addr = 26'h1234567;
    tick();
    checks++;
    if (ic_gnt !== 1'b0 || l2_req !== 1'b1 || l2_addr !== 26'h0ABCDE) begin
      errors++;
      $display("[TB] FAIL single_hold: gnt %b req %b addr %h expected 0 1 0abcde",
               ic_gnt, l2_req, l2_addr);
    end
    tick();
    l2_ack = 1'b1;
    tick();
    l2_ack = 1'b0;
    checks++;
    if ({ic_done, dc_done, err, l2_req, busy} !== 5'b10001 || ic_cnt !== 2'd1) begin
      errors++;
      $display("[TB] FAIL single_done: done %b%b err %b req %b busy %b ic_cnt %0d expected 1 0 0 0 1 cnt 1",
               ic_done, dc_done, err, l2_req, busy, ic_cnt);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || ic_done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: busy %b done %b expected 0 0", busy, ic_done);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_dc;
    logic [ADDR_W-1:0] exp_addr;
    ic_req  = 1'b1;
    ic_addr = 26'h0ABCDE;
    dc_req  = 1'b1;
    dc_we   = 1'b1;
    dc_addr = 26'h0000040;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_dc   = (i % 2) == 1;
      exp_addr = exp_dc ? 26'h0000040 : 26'h0ABCDE;
      tick();
      checks++;
      if (ic_gnt !== !exp_dc || dc_gnt !== exp_dc || l2_we !== exp_dc || l2_addr !== exp_addr) begin
        errors++;
        $display("[TB] FAIL rr_grant_%0d: gnt %b%b we %b addr %h expected %b%b we %b addr %h",
                 i, ic_gnt, dc_gnt, l2_we, l2_addr, !exp_dc, exp_dc, exp_dc, exp_addr);
      end
      l2_ack = 1'b1;
      tick();
      l2_ack = 1'b0;
      checks++;
      if (ic_done !== !exp_dc || dc_done !== exp_dc || err !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rr_done_%0d: done %b%b err %b expected %b%b err 0",
                 i, ic_done, dc_done, err, !exp_dc, exp_dc);
      end
      tick();
      checks++;
      if (ic_gnt !== 1'b0 || dc_gnt !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rr_gap_%0d: gnt %b%b busy %b expected 00 busy 0",
                 i, ic_gnt, dc_gnt, busy);
      end
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    checks++;
    if (ic_cnt !== 2'd2 || dc_cnt !== 2'd2) begin
      errors++;
      $display("[TB] FAIL rr_counts: ic_cnt %0d dc_cnt %0d expected 2 2", ic_cnt, dc_cnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    int high_cycles;
    do_reset();
    dc_req  = 1'b1;
    dc_we   = 1'b1;
    dc_addr = 26'h0000080;
    tick();
    dc_req = 1'b0;
    high_cycles = (l2_req === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (l2_req !== 1'b1) break;
      high_cycles++;
    end
    checks++;
    if (high_cycles != 4) begin
      errors++;
      $display("[TB] FAIL timeout_len: l2_req high %0d cycles expected 4", high_cycles);
    end
    checks++;
    if (err !== 1'b1 || dc_done !== 1'b1 || ic_done !== 1'b0 || dc_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL timeout_abort: err %b dc_done %b ic_done %b dc_cnt %0d expected 1 1 0 0",
               err, dc_done, ic_done, dc_cnt);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || err !== 1'b0 || dc_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL timeout_idle: busy %b err %b dc_cnt %0d expected 0 0 0", busy, err, dc_cnt);
    end
  endtask

  task automatic test_ack_timeout_tie();
    ic_req  = 1'b1;
    ic_addr = 26'h0000100;
    tick();
    ic_req = 1'b0;
    tick();
    tick();
    tick();
    l2_ack = 1'b1;
    tick();
    l2_ack = 1'b0;
    checks++;
    if (ic_done !== 1'b1 || err !== 1'b0 || ic_cnt !== 2'd1) begin
      errors++;
      $display("[TB] FAIL tie_ack_wins: ic_done %b err %b ic_cnt %0d expected 1 0 1",
               ic_done, err, ic_cnt);
    end
    tick();
  endtask

  task automatic test_stray_ack();
    l2_ack = 1'b1;
    tick();
    l2_ack = 1'b0;
    checks++;
    if ({ic_done, dc_done, err, busy, l2_req} !== 5'b0 || ic_cnt !== 2'd1 || dc_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL ack_in_idle: flags %b ic_cnt %0d dc_cnt %0d expected 00000 1 0",
               {ic_done, dc_done, err, busy, l2_req}, ic_cnt, dc_cnt);
    end
    ic_req = 1'b1;
    tick();
    ic_req = 1'b0;
    l2_ack = 1'b1;
    tick();
    tick();
    l2_ack = 1'b0;
    checks++;
    if ({ic_done, dc_done, err, busy} !== 4'b0 || ic_cnt !== 2'd2 || dc_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL ack_in_done: flags %b ic_cnt %0d dc_cnt %0d expected 0000 2 0",
               {ic_done, dc_done, err, busy}, ic_cnt, dc_cnt);
    end
  endtask

  task automatic test_async_reset();
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 26'h0000200;
    tick();
    dc_req = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (l2_req !== 1'b0 || busy !== 1'b0 || ic_cnt !== 2'd0 || dc_cnt !== 2'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: req %b busy %b ic_cnt %0d dc_cnt %0d expected 0 0 0 0",
               l2_req, busy, ic_cnt, dc_cnt);
    end
    tick();
    rst_n = 1'b1;
    l2_ack = 1'b1;
    tick();
    l2_ack = 1'b0;
    checks++;
    if ({ic_done, dc_done, err, busy, l2_req} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL async_no_pulse: flags %b expected 00000",
               {ic_done, dc_done, err, busy, l2_req});
    end
  endtask

  task automatic test_saturation();
    int exp_sat[5] = '{1, 2, 3, 3, 3};
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    ic_addr = 26'h0000300;
    for (int i = 0; i < 5; i++) begin
      exp_cnt = CNT_W'(exp_sat[i]);
      ic_req = 1'b1;
      tick();
      ic_req = 1'b0;
      l2_ack = 1'b1;
      tick();
      l2_ack = 1'b0;
      checks++;
      if (ic_done !== 1'b1 || ic_cnt !== exp_cnt) begin
        errors++;
        $display("[TB] FAIL sat_%0d: ic_done %b ic_cnt %0d expected 1 %0d",
                 i, ic_done, ic_cnt, exp_cnt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_ic();
    test_back_to_back();
    test_timeout();
    test_ack_timeout_tie();
    test_stray_ack();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so that the run always terminates, even if a task stalls.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
